// File: rtl/algo_mrnw_pkg.sv
// Shared types for the multi-port memory read-response path.
package algo_mrnw_pkg;

    // Read-response queue control state.
    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Data width of the default memory configuration.
    localparam int unsigned RSP_WIDTH = 32;

    // Response entry as stored in the FIFO: error flags above the data word.
    typedef struct packed {
        logic                 derr;
        logic                 serr;
        logic [RSP_WIDTH-1:0] data;
    } rsp_entry_t;

endpackage

// File: rtl/algo_sync_fifo.sv
// Synchronous FIFO holding read responses; pop is applied before push when full.
module algo_sync_fifo #(
    parameter int unsigned WIDTH   = 34,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned BITDPTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [WIDTH-1:0]   pushData,
    input  logic               pop,
    output logic [WIDTH-1:0]   headData,
    output logic [BITDPTH:0]   level,
    output logic               full,
    output logic               empty
);

    localparam int unsigned CNT_W = BITDPTH + 1;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [BITDPTH-1:0] wrPtr;
    logic [BITDPTH-1:0] rdPtr;
    logic [CNT_W-1:0]   count;
    logic               doPush;
    logic               doPop;

    // Pointer increment that wraps at DEPTH even when DEPTH is not a power of two.
    function automatic logic [BITDPTH-1:0] nextPtr(input logic [BITDPTH-1:0] p);
        if (p == BITDPTH'(DEPTH - 1)) begin
            return '0;
        end
        return p + BITDPTH'(1);
    endfunction

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign level  = count;

    // Head is forced to zero while empty so stale storage never leaks out.
    assign headData = empty ? '0 : mem[rdPtr];

    // Storage array: written on accepted push, intentionally not reset.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= nextPtr(wrPtr);
            end
            if (doPop) begin
                rdPtr <= nextPtr(rdPtr);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/algo_1r6w_rd_rsp_queue.sv
// Read request/response front end for the 1r6w memory: credit-gated issue,
// fixed-latency return tracking and an in-order response FIFO.
module algo_1r6w_rd_rsp_queue
    import algo_mrnw_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned BITADDR = 13,
    parameter int unsigned RD_LAT  = 3,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned BITDPTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_ready,
    input  logic               req_vld,
    output logic               req_rdy,
    input  logic [BITADDR-1:0] req_adr,
    output logic               read,
    output logic [BITADDR-1:0] rd_adr,
    input  logic               rd_vld,
    input  logic [WIDTH-1:0]   rd_dout,
    input  logic               rd_serr,
    input  logic               rd_derr,
    output logic               rsp_vld,
    input  logic               rsp_rdy,
    output logic [WIDTH-1:0]   rsp_dout,
    output logic               rsp_serr,
    output logic               rsp_derr,
    output logic               err_unexp,
    output logic               err_ovf,
    output logic [BITDPTH:0]   level
);

    localparam int unsigned ENTRY_W = WIDTH + 2;
    localparam int unsigned CNT_W   = BITDPTH + 1;
    localparam int unsigned SUM_W   = BITDPTH + 2;

    state_t             stateQ;
    state_t             stateD;
    logic [CNT_W-1:0]   inflightQ;
    logic [RD_LAT-1:0]  expSr;
    logic [SUM_W-1:0]   creditSum;
    logic               creditOk;
    logic               rdExp;
    logic               rdUnexp;
    logic               fifoPop;
    logic               fifoFull;
    logic               fifoEmpty;
    logic [ENTRY_W-1:0] headData;

    // Reads in flight plus queued responses may never exceed the FIFO depth.
    assign creditSum = SUM_W'(inflightQ) + SUM_W'(level);
    assign creditOk  = (creditSum < SUM_W'(DEPTH));

    // A return is legitimate only if an issue sits at the RD_LAT tap.
    assign rdExp   = rd_vld && expSr[RD_LAT-1];
    assign rdUnexp = rd_vld && !expSr[RD_LAT-1];
    assign fifoPop = rsp_rdy && !fifoEmpty;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ <= INIT;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next state plus pass-through issue to the memory read port.
    always_comb begin
        stateD  = stateQ;
        req_rdy = 1'b0;
        read    = 1'b0;
        rd_adr  = '0;
        case (stateQ)
            INIT: if (mem_ready) stateD = RUN;
            RUN:  if (!mem_ready && (inflightQ == '0)) stateD = INIT;
            default: stateD = INIT;
        endcase
        req_rdy = (stateQ == RUN) && mem_ready && creditOk;
        read    = req_vld && req_rdy;
        if (read) begin
            rd_adr = req_adr;
        end
    end

    // In-flight read count; an issue and a return in one cycle cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflightQ <= '0;
        end else begin
            case ({read, rdExp})
                2'b10:   inflightQ <= inflightQ + CNT_W'(1);
                2'b01:   inflightQ <= inflightQ - CNT_W'(1);
                default: inflightQ <= inflightQ;
            endcase
        end
    end

    // Expectation shift register marking the cycle each issued read returns.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            expSr <= '0;
        end else begin
            expSr[0] <= read;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                expSr[i] <= expSr[i-1];
            end
        end
    end

    // Sticky protocol error flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_unexp <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            if (rdUnexp) begin
                err_unexp <= 1'b1;
            end
            if (rdExp && fifoFull && !fifoPop) begin
                err_ovf <= 1'b1;
            end
        end
    end

    algo_sync_fifo #(
        .WIDTH   (ENTRY_W),
        .DEPTH   (DEPTH),
        .BITDPTH (BITDPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rdExp),
        .pushData ({rd_derr, rd_serr, rd_dout}),
        .pop      (rsp_rdy),
        .headData (headData),
        .level    (level),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    assign rsp_vld  = !fifoEmpty;
    assign rsp_derr = headData[WIDTH+1];
    assign rsp_serr = headData[WIDTH];
    assign rsp_dout = headData[WIDTH-1:0];

endmodule

// File: doc/algo_1r6w_rd_rsp_queue.md
ALGO_1R6W_RD_RSP_QUEUE -- requirements
Module: algo_1r6w_rd_rsp_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of the 1r6w memory read port.
REQ-002 SHALL have parameter BITADDR, default 13, address width.
REQ-003 SHALL have parameter RD_LAT, default 3, fixed read latency (read issue to rd_vld), range 1..15.
REQ-004 SHALL have parameter DEPTH, default 8, and BITDPTH, default 3, response FIFO entries and log2; DEPTH SHALL be >= RD_LAT+1.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous assert, active-low; synchronous deassert done externally.
REQ-007 mem_ready  in  1  memory ready (post-refresh/init).
REQ-008 req_vld / req_rdy  in/out  1/1  client read request handshake; req_adr  in  BITADDR.
REQ-009 read  out  1 and rd_adr  out  BITADDR  memory read port.
REQ-010 rd_vld  in  1; rd_dout  in  WIDTH; rd_serr, rd_derr  in  1  memory read return.
REQ-011 rsp_vld / rsp_rdy  out/in  1/1  response handshake; rsp_dout  out  WIDTH; rsp_serr, rsp_derr  out  1.
REQ-012 err_unexp, err_ovf  out  1  sticky protocol errors; level  out  BITDPTH+1  FIFO occupancy.

Function
REQ-013 FSM states INIT, RUN; INIT -> RUN on mem_ready=1; RUN -> INIT on mem_ready=0 sampled while no reads in flight, else stay RUN until in-flight count reaches 0.
REQ-014 req_rdy SHALL equal (state==RUN) && mem_ready && (inflight+level < DEPTH), combinational from registered state only.
REQ-015 On req_vld&&req_rdy, read SHALL assert in the same cycle with rd_adr=req_adr (zero-latency pass-through, no request buffering).
REQ-016 inflight counter (BITDPTH+1 bits) SHALL increment on issued read, decrement on rd_vld, unchanged when both occur same cycle.
REQ-017 A RD_LAT-deep expectation shift register SHALL record each issue; rd_vld while the tap at RD_LAT is 0 SHALL set err_unexp and the data SHALL be discarded.
REQ-018 Expected rd_vld (tap=1) SHALL push {rd_derr, rd_serr, rd_dout} into the FIFO; push when full SHALL set err_ovf and drop the word (unreachable under REQ-014).
REQ-019 rsp_vld SHALL be 1 whenever level>0; rsp_dout/serr/derr SHALL present FIFO head; pop on rsp_vld&&rsp_rdy.
REQ-020 Simultaneous push and pop SHALL keep level unchanged, including at level=DEPTH (pop first) and level=0 (no bypass; data appears next cycle).
REQ-021 Response order SHALL equal request order; minimum req-to-rsp_vld latency is RD_LAT+1 cycles.
REQ-022 Pointers SHALL wrap modulo DEPTH; level SHALL range 0..DEPTH.
REQ-023 rsp_vld SHALL stay asserted and rsp_dout stable until accepted.

Reset
REQ-024 On rst=0: state=INIT, inflight=0, level=0, pointers=0, shift register=0, err_unexp=0, err_ovf=0.
REQ-025 During/after reset: req_rdy=0, read=0, rd_adr=0, rsp_vld=0, rsp_dout=0, rsp_serr=0, rsp_derr=0 until first valid push.
REQ-026 Reset mid-operation SHALL abandon in-flight reads; returns arriving after deassert SHALL flag err_unexp.
REQ-027 FIFO storage array SHALL NOT be reset.

Structure
REQ-028 FSM state enum and the packed response entry type {derr,serr,data} SHALL live in shared package algo_mrnw_pkg.
REQ-029 One sub-module, algo_sync_fifo (parameters WIDTH+2, DEPTH, BITDPTH), SHALL hold the response storage; the top holds FSM, credit and latency logic.

Verification
REQ-030 Reset then mem_ready=1: req_rdy=1 at cycle 1 after RUN; level=0, rsp_vld=0.
REQ-031 Issue adr 0x0010..0x0017 back-to-back, rsp_rdy=0, model returns after 3 cycles: exactly 8 reads accepted, req_rdy=0 at 8, level=8, err_ovf=0.
REQ-032 Then rsp_rdy=1: 8 responses in address order, one per cycle, level 8->0.
REQ-033 Inject rd_vld with no issued read: err_unexp=1 and held until reset; level unchanged.
REQ-034 Return with rd_derr=1 on 3rd of 4 reads: only 3rd response has rsp_derr=1.
REQ-035 mem_ready drops with 2 reads in flight: both responses delivered, then state INIT, req_rdy=0.
